// File: rtl/chaser_pkg.sv
// Shared encodings for the LED chaser: pattern modes, controller states and bounce direction.
package chaser_pkg;

    localparam logic [2:0] MODE_STOP   = 3'd0;
    localparam logic [2:0] MODE_ROT_L  = 3'd1;
    localparam logic [2:0] MODE_ROT_R  = 3'd2;
    localparam logic [2:0] MODE_BOUNCE = 3'd3;
    localparam logic [2:0] MODE_BLINK  = 3'd4;
    localparam logic [2:0] MODE_FILL   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Modes that actually animate; STOP and the two unused codes just hold the LEDs.
    function automatic logic mode_active(input logic [2:0] mode);
        return (mode >= MODE_ROT_L) && (mode <= MODE_FILL);
    endfunction

endpackage

// File: rtl/chaser_tick_gen.sv
// Step-period prescaler: pulses tick on the enabled cycle where the count reaches div.
module chaser_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;

    assign tick = enable && (cnt_r == div);

    // Count only while enabled; wrap to zero on the tick so cnt never exceeds div.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable) begin
            cnt_r <= tick ? '0 : cnt_r + DIV_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/chaser_sequencer.sv
// Command-driven LED chaser: loads a pattern/rate, then steps the LED register while run is high.
module chaser_sequencer
    import chaser_pkg::*;
#(
    parameter int N           = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             run,
    output logic [N-1:0]     leds,
    output logic             step,
    output logic [2:0]       cur_mode
);

    localparam logic [N-1:0] LED_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [N-1:0]     leds_r, leds_s, adv_leds_s, seed_s;
    logic             dir_r, dir_s, adv_dir_s;
    logic [2:0]       cur_mode_r;
    logic [DIV_W-1:0] div_r;
    logic             step_r, cmd_ready_r;
    logic             accept_s, enable_s, tick_s;

    assign accept_s = cmd_valid && cmd_ready_r;
    // A new command suppresses a step that would fire in the same cycle.
    assign enable_s = (state_r == ST_RUN) && run && !accept_s;

    chaser_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept_s),
        .enable (enable_s),
        .div    (div_r),
        .tick   (tick_s)
    );

    // Seed pattern for an incoming command; STOP and unused codes keep the current LEDs.
    always_comb begin
        seed_s = leds_r;
        case (cmd_mode)
            MODE_ROT_L, MODE_ROT_R, MODE_BOUNCE: seed_s = LED_ONE;
            MODE_BLINK:                          seed_s = '1;
            MODE_FILL:                           seed_s = '0;
            default:                             seed_s = leds_r;
        endcase
    end

    // One step of the active pattern; bounce reverses at the ends without dwelling.
    always_comb begin
        adv_leds_s = leds_r;
        adv_dir_s  = dir_r;
        case (cur_mode_r)
            MODE_ROT_L: adv_leds_s = {leds_r[N-2:0], leds_r[N-1]};
            MODE_ROT_R: adv_leds_s = {leds_r[0], leds_r[N-1:1]};
            MODE_BOUNCE: begin
                if ((dir_r == DIR_LEFT) && leds_r[N-1]) begin
                    adv_dir_s  = DIR_RIGHT;
                    adv_leds_s = {1'b0, leds_r[N-1:1]};
                end else if ((dir_r == DIR_RIGHT) && leds_r[0]) begin
                    adv_dir_s  = DIR_LEFT;
                    adv_leds_s = {leds_r[N-2:0], 1'b0};
                end else if (dir_r == DIR_LEFT) begin
                    adv_leds_s = {leds_r[N-2:0], 1'b0};
                end else begin
                    adv_leds_s = {1'b0, leds_r[N-1:1]};
                end
            end
            MODE_BLINK: adv_leds_s = ~leds_r;
            MODE_FILL: begin
                if (&leds_r) begin
                    adv_leds_s = '0;
                end else begin
                    adv_leds_s = {leds_r[N-2:0], 1'b1};
                end
            end
            default: adv_leds_s = leds_r;
        endcase
    end

    // Next-state and LED update; an accepted command always wins and lands in LOAD.
    always_comb begin
        state_s = state_r;
        leds_s  = leds_r;
        dir_s   = dir_r;
        if (accept_s) begin
            state_s = ST_LOAD;
            leds_s  = seed_s;
            dir_s   = DIR_LEFT;
        end else begin
            case (state_r)
                ST_IDLE:  state_s = ST_IDLE;
                ST_LOAD: begin
                    if (!mode_active(cur_mode_r)) begin
                        state_s = ST_IDLE;
                    end else if (run) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                ST_RUN: begin
                    state_s = run ? ST_RUN : ST_PAUSE;
                    if (tick_s) begin
                        leds_s = adv_leds_s;
                        dir_s  = adv_dir_s;
                    end else begin
                        leds_s = leds_r;
                        dir_s  = dir_r;
                    end
                end
                ST_PAUSE: state_s = run ? ST_RUN : ST_PAUSE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // Controller and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            leds_r      <= LED_ONE;
            dir_r       <= DIR_LEFT;
            cur_mode_r  <= MODE_STOP;
            div_r       <= DIV_W'(DEFAULT_DIV);
            step_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            leds_r      <= leds_s;
            dir_r       <= dir_s;
            cur_mode_r  <= accept_s ? cmd_mode : cur_mode_r;
            div_r       <= accept_s ? cmd_div : div_r;
            step_r      <= tick_s;
            cmd_ready_r <= (state_s != ST_LOAD);
        end
    end

    assign leds      = leds_r;
    assign step      = step_r;
    assign cur_mode  = cur_mode_r;
    assign cmd_ready = cmd_ready_r;

endmodule

// File: tb/tb_chaser_sequencer.sv
// Bench for chaser_sequencer: closed-form pattern model plus directed and randomized commands.
module tb_chaser_sequencer;

    localparam int N     = 8;
    localparam int DIV_W = 16;
    localparam logic [N-1:0] ONE = 8'h01;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_mode = 3'd0;
    logic [DIV_W-1:0] cmd_div = 16'd0;
    logic             run = 1'b0;
    logic [N-1:0]     leds;
    logic             step;
    logic [2:0]       cur_mode;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Model: pattern is a pure function of the number of steps taken since the load.
    logic [N-1:0] m_leds;
    logic [2:0]   m_mode;
    int           m_div, m_k, m_c;
    bit           m_load, m_active, m_prev_run, m_step, m_ready;

    chaser_sequencer #(.N(N), .DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_div   (cmd_div),
        .run       (run),
        .leds      (leds),
        .step      (step),
        .cur_mode  (cur_mode)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] pat(input int mode, input int k);
        int j;
        case (mode)
            1: pat = ONE << (k % N);
            2: pat = ONE << ((N - (k % N)) % N);
            3: begin
                j = k % (2 * N - 2);
                pat = (j < N) ? (ONE << j) : (ONE << (2 * N - 2 - j));
            end
            4: pat = ((k % 2) == 0) ? 8'hFF : 8'h00;
            5: begin
                j = k % (N + 1);
                pat = (ONE << j) - ONE;
            end
            default: pat = 8'h00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_edge();
        if (rst) begin
            m_leds = ONE; m_mode = 3'd0; m_div = 4; m_k = 0; m_c = 0;
            m_load = 1'b0; m_active = 1'b0; m_step = 1'b0; m_ready = 1'b1;
        end else if (cmd_valid && m_ready) begin
            m_mode   = cmd_mode;
            m_div    = int'(cmd_div);
            m_k      = 0;
            m_c      = 0;
            m_load   = 1'b1;
            m_active = (cmd_mode >= 3'd1) && (cmd_mode <= 3'd5);
            if (m_active) m_leds = pat(int'(cmd_mode), 0);
            m_step   = 1'b0;
            m_ready  = 1'b0;
        end else begin
            m_ready = 1'b1;
            m_step  = 1'b0;
            // A cycle counts only when run was high on the previous cycle and this one.
            if (m_active && !m_load && m_prev_run && run) begin
                if (m_c == m_div) begin
                    m_c = 0;
                    m_k++;
                    m_step = 1'b1;
                    m_leds = pat(int'(m_mode), m_k);
                end else begin
                    m_c++;
                end
            end
            m_load = 1'b0;
        end
        m_prev_run = run;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] mode, input logic [DIV_W-1:0] div);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_div   = div;
        cycle();
        cmd_valid = 1'b0;
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("leds", 32'(leds), 32'(m_leds));
            chk("step", 32'(step), 32'(m_step));
            chk("cur_mode", 32'(cur_mode), 32'(m_mode));
            chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
        end
    end

    initial begin
        cycle();
        cycle();
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("rst_leds", 32'(leds), 32'h01);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_mode", 32'(cur_mode), 32'h0);

        run = 1'b1;
        repeat (20) cycle();
        chk("stop_hold", 32'(leds), 32'h01);

        send(3'd1, 16'd2);
        chk("load_ready", 32'(cmd_ready), 32'h0);
        chk("load_seed", 32'(leds), 32'h01);
        repeat (4) cycle();
        chk("rotl_first", 32'(leds), 32'h02);
        chk("rotl_step", 32'(step), 32'h1);
        repeat (21) cycle();
        chk("rotl_wrap", 32'(leds), 32'h01);

        send(3'd3, 16'd0);
        repeat (8) cycle();
        chk("bounce_top", 32'(leds), 32'h80);
        cycle();
        chk("bounce_rev", 32'(leds), 32'h40);
        repeat (6) cycle();
        chk("bounce_bot", 32'(leds), 32'h01);
        cycle();
        chk("bounce_up", 32'(leds), 32'h02);

        send(3'd5, 16'd0);
        chk("fill_seed", 32'(leds), 32'h00);
        repeat (9) cycle();
        chk("fill_full", 32'(leds), 32'hFF);
        cycle();
        chk("fill_clear", 32'(leds), 32'h00);

        send(3'd4, 16'd0);
        chk("blink_seed", 32'(leds), 32'hFF);
        repeat (2) cycle();
        chk("blink_off", 32'(leds), 32'h00);

        send(3'd2, 16'd3);
        repeat (3) cycle();
        run = 1'b0;
        repeat (5) cycle();
        chk("pause_leds", 32'(leds), 32'h01);
        chk("pause_step", 32'(step), 32'h0);
        run = 1'b1;
        repeat (2) cycle();
        chk("resume_wait", 32'(leds), 32'h01);
        cycle();
        chk("resume_step", 32'(leds), 32'h80);

        send(3'd7, 16'd1);
        repeat (3) cycle();
        chk("illegal_hold", 32'(leds), 32'h80);
        chk("illegal_mode", 32'(cur_mode), 32'h7);

        send(3'd1, 16'd1);
        repeat (2) cycle();
        send(3'd4, 16'd0);
        chk("collide_step", 32'(step), 32'h0);
        chk("collide_seed", 32'(leds), 32'hFF);

        send(3'd1, 16'd0);
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrun_rst_leds", 32'(leds), 32'h01);
        chk("midrun_rst_mode", 32'(cur_mode), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 11) == 0);
            cmd_mode  = 3'($urandom_range(0, 7));
            cmd_div   = 16'($urandom_range(0, 3));
            run       = ($urandom_range(0, 4) != 0);
            rst       = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/chaser_sequencer.md
Name: chaser_sequencer

Overview:
- Controller for the LED light-chaser datapath. It sequences an N-bit LED register through selectable patterns at a programmable step rate.
- Replaces the free-running enable-only chaser with a command-driven, pausable scheduler.
- Sits between the board control logic (command source, run switch) and the LED pins.

Parameters:
- N, 8, number of LEDs (>= 2)
- DIV_W, 16, width of the step-period divider
- DEFAULT_DIV, 4, divider value loaded at reset

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command this cycle
- cmd_mode  input  3  pattern select (see Behaviour)
- cmd_div  input  DIV_W  step period minus one, in clk cycles
- run  input  1  1 = advance pattern, 0 = pause (hold everything)
- leds  output  N  LED drive
- step  output  1  one-cycle pulse, coincident with each new leds value
- cur_mode  output  3  currently active mode

Behaviour:
- Reset values (rst sampled high on a clk edge):
  - leds=1 (LSB only), cur_mode=STOP, div=DEFAULT_DIV, cnt=0, dir=LEFT
  - step=0, cmd_ready=1, state=IDLE
  - rst overrides every other input, mid-command or mid-pattern.
- Modes:
  - 0 STOP: hold leds.
  - 1 ROT_L: leds <= {leds[N-2:0],leds[N-1]}.
  - 2 ROT_R: leds <= {leds[0],leds[N-1:1]}.
  - 3 BOUNCE: single lit bit moves per dir; dir flips when the next move would leave the ends (bit N-1 lit while LEFT, or bit 0 lit while RIGHT). At each end the bit reverses with no dwell, so the sequence 0x40,0x80,0x40 is correct for N=8.
  - 4 BLINK: leds <= ~leds.
  - 5 FILL: leds <= {leds[N-2:0],1'b1} until all ones; the next step goes to all zeros, then repeats.
  - 6, 7: illegal; accepted and treated as STOP.
- Seeds applied on load:
  - ROT_L, ROT_R, BOUNCE: 0..01
  - BLINK: all ones
  - FILL: all zeros
  - STOP: leds unchanged
  - dir=LEFT for all modes.
- FSM states: IDLE, LOAD, RUN, PAUSE.
  - Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready=1 in IDLE, RUN and PAUSE; 0 in LOAD.
  - Any state --accept--> LOAD: latch cur_mode and div.
  - LOAD (exactly 1 cycle): leds=seed, cnt=0, step=0. Then go to IDLE if the mode is STOP or illegal, else RUN if run=1, else PAUSE.
  - RUN: when run=1 and cnt==div, set cnt=0, update leds, step=1 for one cycle. Otherwise increment cnt while run=1.
  - RUN --run=0--> PAUSE. PAUSE holds cnt and leds. PAUSE --run=1--> RUN, and counting resumes from the held cnt.
- Latency:
  - First step occurs div+1 RUN cycles after LOAD.
  - Step period is div+1 cycles. div=0 steps every cycle.
  - cnt is DIV_W bits and never exceeds div.
- Simultaneous events: a command accepted in the same cycle a step would fire wins. That step is suppressed, and leds take the new seed in the next cycle.
- step is never high outside RUN.

Decomposition:
- chaser_pkg:
  - mode encodings MODE_STOP..MODE_FILL (3-bit localparams)
  - FSM state encoding (2-bit)
  - DIR_LEFT and DIR_RIGHT constants
- One sub-module, chaser_tick_gen: the cnt/div prescaler.
  - Inputs: clk, rst, clear, enable, div.
  - Output: tick.
  - The pattern logic and FSM stay in chaser_sequencer.

Test Plan:
- Reset → leds=0x01, cur_mode=0, cmd_ready=1, step=0. Holding run=1 for 20 cycles leaves leds unchanged.
- Cmd ROT_L, div=2, run=1 → cmd_ready=0 for one cycle. leds=0x01, then 0x02, 0x04, ... 0x80, 0x01, with exactly 3 cycles between steps and step high on each change.
- BOUNCE, div=0 → leds 0x01, 0x02 … 0x80, 0x40 … 0x01, 0x02, changing every cycle. dir flip verified at both ends.
- FILL, div=0 → leds 0x00, 0x01, 0x03 … 0xFF, 0x00. BLINK, div=0 → 0xFF, 0x00, 0xFF.
- ROT_R, div=3: drop run for 5 cycles mid-count → leds and cnt frozen, no step. Resume → remaining cycles counted, not restarted. Illegal mode 7 → IDLE, leds held.
- Command issued on a step cycle → no step that cycle, new seed next cycle. rst asserted mid-RUN → all reset values the next cycle.
